// File: rtl/mlp_host_driver.sv
// mlp_host_driver: initiator side of the MLP core start/done protocol with input packing, weight store and result stream
//   clk, rst (async active-low) | s_data/s_valid/s_ready: input words | w_addr/w_data/w_we/w_ready: weight byte port
//   mlp_*: packed inputs, weights, start pulse, core result/done | m_data/m_valid/m_ready/m_timeout: result | busy: run in flight
module mlp_host_driver #(
  parameter int WORDSIZE  = 8,
  parameter int DIMENSION = 7,
  parameter int TIMEOUT   = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WORDSIZE-1:0]               s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [4:0]                        w_addr,
  input  logic [WORDSIZE-1:0]               w_data,
  input  logic                              w_we,
  output logic                              w_ready,
  output logic [DIMENSION*WORDSIZE-1:0]     mlp_data_in,
  output logic [(DIMENSION+1)*WORDSIZE-1:0] mlp_weight_1_1,
  output logic [(DIMENSION+1)*WORDSIZE-1:0] mlp_weight_1_2,
  output logic [3*WORDSIZE-1:0]             mlp_weight_2_1,
  output logic                              mlp_start,
  input  logic [WORDSIZE-1:0]               mlp_data_out,
  input  logic                              mlp_done,
  output logic [WORDSIZE-1:0]               m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              m_timeout,
  output logic                              busy
);
  localparam int NW = 2*(DIMENSION+1)+3;
  localparam int CW = $clog2(DIMENSION+1);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {S_LOAD, S_FIRE, S_ARM, S_WAIT, S_RESULT} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tmo;
  logic [NW*WORDSIZE-1:0] r_wt;
  logic [DIMENSION*WORDSIZE-1:0] r_in;
  logic [WORDSIZE-1:0] r_mdata;
  logic r_mtmo;
  logic w_s_hs, w_tmo_hit;
  assign s_ready = r_state == S_LOAD && r_cnt < CW'(DIMENSION);
  assign w_ready = r_state == S_LOAD;
  assign w_s_hs = s_valid && s_ready;
  assign w_tmo_hit = r_tmo == TW'(TIMEOUT-1);
  assign mlp_start = r_state == S_FIRE;
  assign m_valid = r_state == S_RESULT;
  assign busy = r_state == S_FIRE || r_state == S_ARM || r_state == S_WAIT;
  assign m_data = r_mdata;
  assign m_timeout = r_mtmo;
  assign mlp_data_in = r_in;
  // Weight store is one byte array: group 1_1, then 1_2, then 2_1, bias in the low byte of each
  assign mlp_weight_1_1 = r_wt[(DIMENSION+1)*WORDSIZE-1:0];
  assign mlp_weight_1_2 = r_wt[2*(DIMENSION+1)*WORDSIZE-1 -: (DIMENSION+1)*WORDSIZE];
  assign mlp_weight_2_1 = r_wt[NW*WORDSIZE-1 -: 3*WORDSIZE];
  always_comb begin
    w_next = r_state;
    case (r_state)
      // Jump straight to FIRE on the last word so start follows the final handshake by one cycle
      S_LOAD:   w_next = w_s_hs && r_cnt == CW'(DIMENSION-1) ? S_FIRE : S_LOAD;
      S_FIRE:   w_next = S_ARM;
      // ARM ignores done: the core may still be holding done from the previous run
      S_ARM:    w_next = S_WAIT;
      S_WAIT:   w_next = mlp_done || w_tmo_hit ? S_RESULT : S_WAIT;
      S_RESULT: w_next = m_ready ? S_LOAD : S_RESULT;
      default:  w_next = S_LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_wt    <= '0;
      r_in    <= '0;
      r_mdata <= '0;
      r_mtmo  <= 1'b0;
    end else begin
      r_state <= w_next;
      for (int k = 0; k < DIMENSION; k++)
        if (w_s_hs && r_cnt == CW'(k)) r_in[k*WORDSIZE +: WORDSIZE] <= s_data;
      for (int k = 0; k < NW; k++)
        if (w_we && w_ready && w_addr == 5'(k)) r_wt[k*WORDSIZE +: WORDSIZE] <= w_data;
      if (w_s_hs) r_cnt <= r_cnt + CW'(1);
      if (r_state == S_FIRE) r_cnt <= '0;
      if (r_state == S_WAIT) begin
        // done has priority over a coinciding timeout
        if (mlp_done) begin
          r_mdata <= mlp_data_out;
          r_mtmo  <= 1'b0;
        end else if (w_tmo_hit) begin
          r_mdata <= '0;
          r_mtmo  <= 1'b1;
        end else r_tmo <= r_tmo + TW'(1);
      end
      if (r_state == S_RESULT && m_ready) r_tmo <= '0;
    end
  end
endmodule

// File: tb/tb_mlp_host_driver.sv
// tb_mlp_host_driver: table-driven and randomized checks of mlp_host_driver against a result/latency model
module tb_mlp_host_driver;
  localparam int TIMEOUT = 255;
  logic clk = 0;
  logic rst = 0;
  logic [7:0] s_data = 0;
  logic s_valid = 0;
  logic s_ready;
  logic [4:0] w_addr = 0;
  logic [7:0] w_data = 0;
  logic w_we = 0;
  logic w_ready;
  logic [55:0] mlp_data_in;
  logic [63:0] mlp_weight_1_1, mlp_weight_1_2;
  logic [23:0] mlp_weight_2_1;
  logic mlp_start;
  logic [7:0] mlp_data_out;
  logic mlp_done;
  logic [7:0] m_data;
  logic m_valid;
  logic m_ready = 0;
  logic m_timeout;
  logic busy;
  int n_chk = 0, n_fail = 0;
  logic [7:0] wb[19];
  logic [7:0] cur_in[7];
  int core_lat = 0;
  logic [7:0] core_val = 0;
  logic core_force = 0;
  logic [7:0] force_val = 0;
  logic core_done_r = 0;
  int k = 0;
  mlp_host_driver dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .w_addr(w_addr), .w_data(w_data), .w_we(w_we), .w_ready(w_ready),
    .mlp_data_in(mlp_data_in), .mlp_weight_1_1(mlp_weight_1_1), .mlp_weight_1_2(mlp_weight_1_2),
    .mlp_weight_2_1(mlp_weight_2_1), .mlp_start(mlp_start), .mlp_data_out(mlp_data_out),
    .mlp_done(mlp_done), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_timeout(m_timeout), .busy(busy)
  );
  always #5 clk = ~clk;
  // Core model: done pulses core_lat cycles after the start cycle (core_lat=0: never); core_force holds done high
  assign mlp_done = core_force | core_done_r;
  assign mlp_data_out = core_force ? force_val : (core_done_r ? core_val : ~core_val);
  always @(posedge clk) begin
    if (mlp_start) begin
      k <= 1;
      core_done_r <= 0;
    end else if (k > 0) begin
      core_done_r <= core_lat > 0 && k == core_lat - 1;
      k <= (core_lat > 0 && k == core_lat - 1) ? 0 : k + 1;
    end else core_done_r <= 0;
  end
  typedef struct {
    int lat; logic [7:0] val; int gap; int hold; logic extra; logic wwait;
    logic [7:0] exp_d; logic exp_t; int exp_c;
  } vec_t;
  vec_t tbl[6];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  task automatic wr_w(input logic [4:0] a, input logic [7:0] d);
    w_addr = a;
    w_data = d;
    w_we = 1;
    tick;
    w_we = 0;
  endtask
  task automatic chk_w;
    logic [63:0] e11, e12;
    logic [23:0] e21;
    for (int i = 0; i < 8; i++) begin
      e11[i*8 +: 8] = wb[i];
      e12[i*8 +: 8] = wb[8+i];
    end
    for (int i = 0; i < 3; i++) e21[i*8 +: 8] = wb[16+i];
    chk("w11", mlp_weight_1_1, e11);
    chk("w12", mlp_weight_1_2, e12);
    chk("w21", {40'h0, mlp_weight_2_1}, {40'h0, e21});
  endtask
  // Higher-level rule: done at start+lat wins unless it lands after the last WAIT cycle (start+TIMEOUT+1)
  task automatic model(input int lat, input logic [7:0] val, output logic [7:0] d, output logic t, output int c);
    t = lat < 2 || lat > TIMEOUT + 1;
    d = t ? 8'h00 : val;
    c = t ? TIMEOUT + 2 : lat + 1;
  endtask
  task automatic stream(input int gap);
    int acc = 0, guard = 0;
    logic hs;
    while (acc < 7 && guard < 200) begin
      s_valid = gap == 0 || guard % 2 == 0;
      s_data = cur_in[acc];
      hs = s_valid && s_ready;
      tick;
      if (hs) acc++;
      guard++;
    end
    s_valid = 0;
    chk("stream_done", acc, 7);
  endtask
  task automatic do_run(input int lat, input logic [7:0] val, input logic [7:0] exp_d, input logic exp_t,
                        input int exp_c, input int gap, input int hold, input logic extra,
                        input logic wwait, input logic unforce);
    logic [55:0] exp_in;
    int c = 0, starts = 1, bad = 0;
    for (int i = 0; i < 7; i++) exp_in[i*8 +: 8] = cur_in[i];
    core_lat = lat;
    core_val = val;
    stream(gap);
    if (extra) begin
      s_valid = 1;
      s_data = 8'hEE;
    end
    chk("start_pulse", mlp_start, 1);
    chk("s_ready_fire", s_ready, 0);
    while (!m_valid && c < 400) begin
      tick;
      c++;
      if (unforce && c == 2) core_force = 0;
      if (mlp_start) starts++;
      if (s_ready) bad++;
      if (c == 1) chk("busy_arm", busy, 1);
      if (wwait && c == 5) begin
        chk("w_ready_wait", w_ready, 0);
        w_addr = 3;
        w_data = 8'hFF;
        w_we = 1;
      end else if (c == 6) w_we = 0;
    end
    chk("latency", c, exp_c);
    chk("start_count", starts, 1);
    chk("s_ready_busy", bad, 0);
    chk("m_data", m_data, exp_d);
    chk("m_timeout", m_timeout, exp_t);
    chk("busy_result", busy, 0);
    chk("data_in", mlp_data_in, exp_in);
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      tick;
      if (!m_valid || m_data !== exp_d || m_timeout !== exp_t) bad++;
    end
    chk("result_hold", bad, 0);
    s_valid = 0;
    m_ready = 1;
    tick;
    m_ready = 0;
    chk("m_valid_clear", m_valid, 0);
    chk("s_ready_load", s_ready, 1);
  endtask
  initial begin
    logic [7:0] ed;
    logic et;
    int ec, lat, cnt;
    tbl[0] = '{4,   8'h5A, 0, 0,  1'b0, 1'b0, 8'h5A, 1'b0, 5};
    tbl[1] = '{3,   8'h3C, 1, 10, 1'b1, 1'b0, 8'h3C, 1'b0, 4};
    tbl[2] = '{0,   8'hFF, 0, 2,  1'b0, 1'b1, 8'h00, 1'b1, 257};
    tbl[3] = '{2,   8'h81, 0, 1,  1'b0, 1'b0, 8'h81, 1'b0, 3};
    tbl[4] = '{256, 8'hA5, 0, 0,  1'b0, 1'b0, 8'hA5, 1'b0, 257};
    tbl[5] = '{257, 8'hA5, 0, 0,  1'b0, 1'b0, 8'h00, 1'b1, 257};
    repeat (3) tick;
    rst = 1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_w_ready", w_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_timeout", m_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", mlp_start, 0);
    chk("rst_data_in", mlp_data_in, 0);
    for (int i = 0; i < 19; i++) wb[i] = 0;
    chk_w;
    for (int i = 0; i < 19; i++) begin
      wb[i] = 8'($urandom);
      wr_w(5'(i), wb[i]);
    end
    chk_w;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 7; i++) cur_in[i] = t == 0 ? 8'(i + 1) : 8'(t * 16 + i);
      do_run(tbl[t].lat, tbl[t].val, tbl[t].exp_d, tbl[t].exp_t, tbl[t].exp_c,
             tbl[t].gap, tbl[t].hold, tbl[t].extra, tbl[t].wwait, 1'b0);
      if (t == 0) chk("data_in_1to7", mlp_data_in, 56'h07060504030201);
      chk_w;
    end
    core_force = 1;
    force_val = 8'h77;
    for (int i = 0; i < 7; i++) cur_in[i] = 8'(8'h40 + i);
    do_run(0, 8'h00, 8'h77, 1'b0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cur_in[i] = 8'(8'h50 + i);
    do_run(5, 8'h11, 8'h11, 1'b0, 6, 0, 0, 1'b0, 1'b0, 1'b1);
    wr_w(5'd20, 8'h99);
    chk_w;
    wr_w(5'd17, 8'hC3);
    wb[17] = 8'hC3;
    chk("w21_byte1", mlp_weight_2_1[15:8], 8'hC3);
    chk_w;
    for (int r = 0; r < 16; r++) begin
      repeat ($urandom_range(0, 3)) begin
        w_addr = 5'($urandom_range(0, 31));
        w_data = 8'($urandom);
        if (w_addr < 19) wb[w_addr] = w_data;
        wr_w(w_addr, w_data);
      end
      for (int i = 0; i < 7; i++) cur_in[i] = 8'($urandom);
      lat = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(2, 9);
      core_val = 8'($urandom);
      model(lat, core_val, ed, et, ec);
      do_run(lat, core_val, ed, et, ec, $urandom_range(0, 1), $urandom_range(0, 3), 1'b0, 1'b0, 1'b0);
      chk_w;
    end
    for (int i = 0; i < 7; i++) cur_in[i] = 8'(8'h60 + i);
    core_lat = 6;
    core_val = 8'h42;
    stream(0);
    repeat (3) tick;
    chk("busy_pre_reset", busy, 1);
    rst = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_data_in", mlp_data_in, 0);
    for (int i = 0; i < 19; i++) wb[i] = 0;
    chk_w;
    tick;
    rst = 1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (m_valid || busy || !s_ready || !w_ready) cnt++;
    end
    chk("post_rst_idle", cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
